// File: rtl/minv_reg_ctrl.sv
// minv_reg_ctrl: command sequencer (load/shift/read) for a 256-bit U/T working register
module minv_reg_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_cnt,
  input  logic        cmd_fill,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        reg_we,
  output logic        reg_sel_cyc,
  output logic        reg_sel_rs,
  output logic        reg_bit256,
  output logic [15:0] reg_din,
  input  logic [15:0] reg_lo
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, READ, DONE} state_t;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_SHIFT = 2'b01, OP_READ = 2'b10;
  state_t state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] scnt_q, scnt_d;
  logic fill_q, fill_d;
  logic load_acc, read_acc, last_word;
  assign load_acc  = state_q == LOAD && din_valid;
  assign read_acc  = state_q == READ && dout_ready;
  assign last_word = wcnt_q == 4'd15;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        wcnt_d  = '0;
        state_d = cmd_op == OP_LOAD ? LOAD : cmd_op == OP_READ ? READ :
                  (cmd_op == OP_SHIFT && cmd_cnt != 8'd0) ? SHIFT : DONE;
        if (cmd_op == OP_SHIFT && cmd_cnt != 8'd0) begin
          scnt_d = cmd_cnt;
          fill_d = cmd_fill;
        end
      end
      LOAD, READ: if (load_acc || read_acc) begin
        wcnt_d  = last_word ? wcnt_q : wcnt_q + 4'd1;
        state_d = last_word ? DONE : state_q;
      end
      // scnt holds at 1 on exit so the count never wraps
      SHIFT: begin
        scnt_d  = scnt_q == 8'd1 ? scnt_q : scnt_q - 8'd1;
        state_d = scnt_q == 8'd1 ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      fill_q  <= fill_d;
    end
  end
  assign cmd_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign din_ready   = state_q == LOAD;
  assign dout_valid  = state_q == READ;
  assign dout        = reg_lo;
  assign reg_din     = din;
  assign reg_we      = load_acc || read_acc || state_q == SHIFT;
  assign reg_sel_cyc = read_acc;
  assign reg_sel_rs  = state_q == SHIFT;
  assign reg_bit256  = state_q == SHIFT && fill_q;
endmodule

// File: tb/tb_minv_reg_ctrl.sv
// tb_minv_reg_ctrl: randomized bench with a word-array model of the 256-bit register contents
module tb_minv_reg_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, cmd_valid = 1'b0, cmd_fill = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [1:0]  cmd_op = 2'b11;
  logic [7:0]  cmd_cnt = 8'd0;
  logic [15:0] din = 16'd0;
  logic        cmd_ready, din_ready, dout_valid, busy, done, reg_we, reg_sel_cyc, reg_sel_rs, reg_bit256;
  logic [15:0] dout, reg_din, reg_lo;
  logic [255:0] r = '0;
  int checks = 0, errors = 0;
  int cyc = 0, we_total = 0, done_total = 0, we_idle = 0;
  logic [15:0] model [16];
  logic [15:0] ld [16];
  logic [15:0] rd [16];

  minv_reg_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done),
    .reg_we(reg_we), .reg_sel_cyc(reg_sel_cyc), .reg_sel_rs(reg_sel_rs), .reg_bit256(reg_bit256),
    .reg_din(reg_din), .reg_lo(reg_lo)
  );

  // stand-in for the external register instance
  assign reg_lo = r[15:0];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_we) begin
      we_total <= we_total + 1;
      r <= reg_sel_rs ? {reg_bit256, r[255:1]} : reg_sel_cyc ? {r[15:0], r[255:16]} : {reg_din, r[255:16]};
    end
    if (done) done_total <= done_total + 1;
    if (reg_we && (cmd_ready || done)) we_idle <= we_idle + 1;
  end

  task automatic model_shift(input int n, input logic f);
    logic [255:0] v, ones;
    ones = '1;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = model[i];
    v = (v >> n) | (f ? ~(ones >> n) : '0);
    for (int i = 0; i < 16; i++) model[i] = v[16*i +: 16];
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] cnt, input logic f, output int acc);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_fill = f;
      #1;
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL cmd_accept got cmd_ready=0 exp 1 within 64 cycles");
      $fatal(1, "command never accepted");
    end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int mode, input bit poke, output int done_cyc, output bit ready_seen);
    int k = 0;
    done_cyc = 0; ready_seen = 0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      din_valid = (k < 16) && (mode == 0 || (mode == 1 && c[0]) || (mode == 2 && $urandom_range(0, 2) != 0));
      din = ld[k[3:0]];
      if (poke) begin cmd_valid = (c == 5); cmd_op = 2'b10; end
      #1;
      if (poke && c == 5 && cmd_ready) ready_seen = 1;
      if (done) begin done_cyc = c; break; end
      if (din_valid && din_ready) k++;
    end
    din_valid = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic do_read(input int mode, output int done_cyc, output int nread);
    nread = 0; done_cyc = 0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      dout_ready = mode == 0 || $urandom_range(0, 2) != 0;
      #1;
      if (done) begin done_cyc = c; break; end
      if (dout_valid && dout_ready) begin
        if (nread < 16) rd[nread] = dout;
        nread++;
      end
    end
    dout_ready = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = 0;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (done) begin done_cyc = c; break; end
    end
  endtask

  task automatic test_reset;
    cmd_valid = 1'b1; cmd_op = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, done, din_ready, dout_valid, reg_we, reg_sel_cyc, reg_sel_rs, reg_bit256} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 100000000",
        {cmd_ready, busy, done, din_ready, dout_valid, reg_we, reg_sel_cyc, reg_sel_rs, reg_bit256});
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_dominates_cmd got done=%b cmd_ready=%b exp done=0 cmd_ready=1", done, cmd_ready);
    end
  endtask

  task automatic test_load_read;
    int acc, dc, n, we0, d0;
    bit rs;
    we0 = we_total; d0 = done_total;
    for (int i = 0; i < 16; i++) ld[i] = 16'h1000 + 16'(i);
    send_cmd(2'b00, 8'd0, 1'b0, acc);
    do_load(0, 0, dc, rs);
    model = ld;
    checks++;
    if (dc != 17) begin errors++; $display("FAIL load_latency got %0d exp 17", dc); end
    checks++;
    if (we_total - we0 != 16) begin errors++; $display("FAIL load_we_count got %0d exp 16", we_total - we0); end
    for (int pass = 0; pass < 2; pass++) begin
      send_cmd(2'b10, 8'd0, 1'b0, acc);
      do_read(0, dc, n);
      checks++;
      if (dc != 17 || n != 16) begin errors++; $display("FAIL read_latency got done=%0d words=%0d exp 17/16", dc, n); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rd[i] !== model[i]) begin errors++; $display("FAIL read%0d_word%0d got %h exp %h", pass, i, rd[i], model[i]); end
      end
    end
    @(negedge clk);
    checks++;
    if (done_total - d0 != 3) begin errors++; $display("FAIL done_pulses got %0d exp 3", done_total - d0); end
  endtask

  task automatic test_shift(input logic [15:0] w0, input logic [15:0] wr, input int n, input logic f);
    int acc, dc, nr, we0;
    bit rs;
    ld[0] = w0;
    for (int i = 1; i < 16; i++) ld[i] = wr;
    send_cmd(2'b00, 8'd0, 1'b0, acc);
    do_load(0, 0, dc, rs);
    model = ld;
    we0 = we_total;
    send_cmd(2'b01, 8'(n), f, acc);
    wait_done(dc);
    model_shift(n, f);
    checks++;
    if (dc != (n == 0 ? 1 : n + 1)) begin errors++; $display("FAIL shift%0d_latency got %0d exp %0d", n, dc, n == 0 ? 1 : n + 1); end
    checks++;
    if (we_total - we0 != n) begin errors++; $display("FAIL shift%0d_we_count got %0d exp %0d", n, we_total - we0, n); end
    send_cmd(2'b10, 8'd0, 1'b0, acc);
    do_read(0, dc, nr);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd[i] !== model[i]) begin errors++; $display("FAIL shift%0d_word%0d got %h exp %h", n, i, rd[i], model[i]); end
    end
  endtask

  task automatic test_load_gaps;
    int acc, dc, nr, we0;
    bit rs;
    for (int i = 0; i < 16; i++) ld[i] = 16'($urandom);
    we0 = we_total;
    send_cmd(2'b00, 8'd0, 1'b0, acc);
    do_load(1, 1, dc, rs);
    model = ld;
    checks++;
    if (dc != 32) begin errors++; $display("FAIL gap_load_latency got %0d exp 32", dc); end
    checks++;
    if (we_total - we0 != 16) begin errors++; $display("FAIL gap_load_we_count got %0d exp 16", we_total - we0); end
    checks++;
    if (rs) begin errors++; $display("FAIL busy_cmd_ready got 1 exp 0"); end
    send_cmd(2'b10, 8'd0, 1'b0, acc);
    do_read(2, dc, nr);
    checks++;
    if (nr != 16) begin errors++; $display("FAIL gap_read_words got %0d exp 16", nr); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd[i] !== model[i]) begin errors++; $display("FAIL gap_word%0d got %h exp %h", i, rd[i], model[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int a1, a2, dc, we0;
    we0 = we_total;
    send_cmd(2'b01, 8'd0, 1'b1, a1);
    wait_done(dc);
    checks++;
    if (dc != 1) begin errors++; $display("FAIL shift0_latency got %0d exp 1", dc); end
    send_cmd(2'b11, 8'd0, 1'b0, a2);
    checks++;
    if (a2 - a1 != 2) begin errors++; $display("FAIL cmd_spacing got %0d exp 2", a2 - a1); end
    wait_done(dc);
    checks++;
    if (dc != 1) begin errors++; $display("FAIL nop_latency got %0d exp 1", dc); end
    send_cmd(2'b11, 8'd0, 1'b0, a1);
    checks++;
    if (a1 - a2 != 2) begin errors++; $display("FAIL nop_nop_spacing got %0d exp 2", a1 - a2); end
    wait_done(dc);
    checks++;
    if (we_total - we0 != 0) begin errors++; $display("FAIL nop_we_count got %0d exp 0", we_total - we0); end
  endtask

  task automatic test_reset_mid_load;
    int acc, dc, nr;
    bit rs;
    for (int i = 0; i < 16; i++) ld[i] = 16'($urandom);
    send_cmd(2'b00, 8'd0, 1'b0, acc);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      din_valid = 1'b1; din = ld[k];
      rst = k == 7;
    end
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, done, busy, din_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_state got %b exp 1000", {cmd_ready, done, busy, din_ready});
    end
    for (int i = 0; i < 16; i++) ld[i] = 16'($urandom);
    send_cmd(2'b00, 8'd0, 1'b0, acc);
    do_load(2, 0, dc, rs);
    model = ld;
    send_cmd(2'b10, 8'd0, 1'b0, acc);
    do_read(0, dc, nr);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd[i] !== model[i]) begin errors++; $display("FAIL post_abort_word%0d got %h exp %h", i, rd[i], model[i]); end
    end
  endtask

  task automatic test_random;
    int acc, dc, nr, n;
    logic f;
    bit rs;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 16; i++) ld[i] = 16'($urandom);
      send_cmd(2'b00, 8'd0, 1'b0, acc);
      do_load(2, 0, dc, rs);
      model = ld;
      checks++;
      if (dc == 0) begin errors++; $display("FAIL rand%0d_load_done got none exp pulse", it); end
      n = $urandom_range(0, 255);
      f = 1'($urandom_range(0, 1));
      send_cmd(2'b01, 8'(n), f, acc);
      wait_done(dc);
      model_shift(n, f);
      checks++;
      if (dc != (n == 0 ? 1 : n + 1)) begin errors++; $display("FAIL rand%0d_shift_latency got %0d exp %0d", it, dc, n == 0 ? 1 : n + 1); end
      send_cmd(2'b10, 8'd0, 1'b0, acc);
      do_read(2, dc, nr);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rd[i] !== model[i]) begin errors++; $display("FAIL rand%0d_word%0d got %h exp %h", it, i, rd[i], model[i]); end
      end
    end
    @(negedge clk);
    checks++;
    if (we_idle != 0) begin errors++; $display("FAIL we_outside_ops got %0d exp 0", we_idle); end
  endtask

  initial begin
    test_reset;
    test_load_read;
    test_shift(16'hFFFF, 16'hFFFF, 1, 1'b0);
    test_shift(16'h0001, 16'h0000, 255, 1'b1);
    test_load_gaps;
    test_back_to_back;
    test_reset_mid_load;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
